// File: rtl/inst_fetch_buf.sv
// Single-line instruction fetch buffer between the PC stage and memory.
// Hits return combinationally; misses stall and refill the line in order.
module inst_fetch_buf #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        stallreq,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFS = CW + 2;
  localparam int TW  = 32 - OFS;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_valid;
  logic            r_kill;
  logic [TW-1:0]   r_tag;
  logic [TW-1:0]   r_fill_tag;
  logic [CW-1:0]   r_cnt;
  logic            r_mem_req;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_data [LINE_WORDS];

  logic            w_idle;
  logic            w_hit;
  logic            w_miss;
  logic            w_ack;
  logic            w_last;
  logic [CW-1:0]   w_cnt_nxt;
  logic [TW-1:0]   w_addr_tag;
  logic [CW-1:0]   w_addr_ofs;
  logic            w_unused_addr;

  assign w_addr_tag    = addr[31:OFS];
  assign w_addr_ofs    = addr[OFS-1:2];
  assign w_unused_addr = ^addr[1:0];

  assign w_idle    = (r_state == IDLE);
  assign w_hit     = ce & r_valid & (r_tag == w_addr_tag) & w_idle;
  assign w_miss    = ce & ~w_hit & w_idle;
  assign w_ack     = ~w_idle & r_mem_req & mem_ack;
  assign w_last    = w_ack & (r_cnt == CW'(LINE_WORDS - 1));
  assign w_cnt_nxt = r_cnt + CW'(1);

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_miss) w_state_nxt = FILL;
      FILL: if (w_last) w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst     = '0;
    stallreq = 1'b0;
    if (ce) begin
      if (w_hit) inst = r_data[w_addr_ofs];
      else       stallreq = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_kill     <= 1'b0;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_fill_tag <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else if (w_idle) begin
      // old valid still drives this cycle's lookup
      if (flush) r_valid <= 1'b0;
      if (w_miss) begin
        r_fill_tag <= w_addr_tag;
        r_cnt      <= '0;
        r_valid    <= 1'b0;
        r_kill     <= 1'b0;
        r_mem_req  <= 1'b1;
        r_mem_addr <= {w_addr_tag, {OFS{1'b0}}};
      end
    end else begin
      if (flush) r_kill <= 1'b1;
      if (w_ack) begin
        r_cnt      <= w_cnt_nxt;
        r_mem_addr <= {r_fill_tag, w_cnt_nxt, 2'b00};
      end
      // a burst hit by flush completes but leaves the line invalid
      if (w_last) begin
        r_mem_req <= 1'b0;
        r_tag     <= r_fill_tag;
        r_valid   <= ~r_kill & ~flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) r_data[r_cnt] <= mem_rdata;
  end

endmodule
